// File: rtl/display_bcd_scheduler.sv
// Frame-synchronous display update controller: snapshots operands at vertical blanking,
// converts them one after another on a single shift-add-3 engine, then commits all at once.
module display_bcd_scheduler (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_start,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_result,
    input  logic       i_sign,
    input  logic       i_overflow,
    input  logic [7:0] i_operand,
    output logic [9:0] o_bcd_a,
    output logic [9:0] o_bcd_b,
    output logic [9:0] o_bcd_res,
    output logic       o_sign_q,
    output logic       o_overflow_q,
    output logic [7:0] o_operand_q,
    output logic       o_busy,
    output logic       o_update_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_COMMIT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_sh_a;
    logic [7:0]  r_sh_b;
    logic [7:0]  r_sh_res;
    logic        r_sh_sign;
    logic        r_sh_ovf;
    logic [7:0]  r_sh_op;

    logic [1:0]  r_sel;
    logic [3:0]  r_cnt;
    logic [7:0]  r_bin;
    logic [9:0]  r_bcd;

    logic [9:0]  r_tmp_a;
    logic [9:0]  r_tmp_b;
    logic [9:0]  r_tmp_res;

    logic [9:0]  r_bcd_a;
    logic [9:0]  r_bcd_b;
    logic [9:0]  r_bcd_res;
    logic        r_sign_q;
    logic        r_ovf_q;
    logic [7:0]  r_op_q;
    logic        r_done;

    logic [7:0]  w_sel_bin;
    logic [3:0]  w_units_adj;
    logic [3:0]  w_tens_adj;
    logic [9:0]  w_bcd_shifted;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_frame_start) w_next = S_LOAD;
            S_LOAD:   w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == 4'd7) w_next = S_STORE;
            S_STORE:  w_next = (r_sel >= 2'd2) ? S_COMMIT : S_LOAD;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Any sel value past 2 decodes to the result slot.
    always_comb begin
        w_sel_bin = r_sh_res;
        case (r_sel)
            2'd0:    w_sel_bin = r_sh_a;
            2'd1:    w_sel_bin = r_sh_b;
            default: w_sel_bin = r_sh_res;
        endcase
    end

    // Hundreds never reaches 5, so only tens and units need the add-3 correction.
    always_comb begin
        w_units_adj   = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_tens_adj    = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_bcd_shifted = {r_bcd[8], w_tens_adj, w_units_adj, r_bin[7]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh_a    <= 8'h00;
            r_sh_b    <= 8'h00;
            r_sh_res  <= 8'h00;
            r_sh_sign <= 1'b0;
            r_sh_ovf  <= 1'b0;
            r_sh_op   <= 8'h00;
            r_sel     <= 2'd0;
            r_cnt     <= 4'd0;
            r_bin     <= 8'h00;
            r_bcd     <= 10'h000;
            r_tmp_a   <= 10'h000;
            r_tmp_b   <= 10'h000;
            r_tmp_res <= 10'h000;
            r_bcd_a   <= 10'h000;
            r_bcd_b   <= 10'h000;
            r_bcd_res <= 10'h000;
            r_sign_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_op_q    <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_sh_a    <= i_a;
                        r_sh_b    <= i_b;
                        r_sh_res  <= i_result;
                        r_sh_sign <= i_sign;
                        r_sh_ovf  <= i_overflow;
                        r_sh_op   <= i_operand;
                        r_sel     <= 2'd0;
                    end
                end
                S_LOAD: begin
                    r_bin <= w_sel_bin;
                    r_bcd <= 10'h000;
                    r_cnt <= 4'd0;
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_shifted;
                    r_bin <= {r_bin[6:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_STORE: begin
                    case (r_sel)
                        2'd0:    r_tmp_a   <= r_bcd;
                        2'd1:    r_tmp_b   <= r_bcd;
                        default: r_tmp_res <= r_bcd;
                    endcase
                    if (r_sel < 2'd2) begin
                        r_sel <= r_sel + 2'd1;
                    end
                end
                S_COMMIT: begin
                    r_bcd_a   <= r_tmp_a;
                    r_bcd_b   <= r_tmp_b;
                    r_bcd_res <= r_tmp_res;
                    r_sign_q  <= r_sh_sign;
                    r_ovf_q   <= r_sh_ovf;
                    r_op_q    <= r_sh_op;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_bcd_a       = r_bcd_a;
    assign o_bcd_b       = r_bcd_b;
    assign o_bcd_res     = r_bcd_res;
    assign o_sign_q      = r_sign_q;
    assign o_overflow_q  = r_ovf_q;
    assign o_operand_q   = r_op_q;
    assign o_busy        = (r_state != S_IDLE);
    assign o_update_done = r_done;

endmodule

// File: tb/tb_display_bcd_scheduler.sv
// Bench for display_bcd_scheduler: a frame-level model predicts committed values and
// handshake timing every cycle, alongside directed literal checks.
module tb_display_bcd_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frameStart = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] result = 8'h00;
    logic       sign = 1'b0;
    logic       overflow = 1'b0;
    logic [7:0] operand = 8'h00;

    logic [9:0] bcdA;
    logic [9:0] bcdB;
    logic [9:0] bcdRes;
    logic       signQ;
    logic       overflowQ;
    logic [7:0] operandQ;
    logic       busy;
    logic       updateDone;

    int vecCount = 0;
    int missCount = 0;
    int donePulses = 0;
    int busyCount = 0;

    display_bcd_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (frameStart),
        .i_a           (a),
        .i_b           (b),
        .i_result      (result),
        .i_sign        (sign),
        .i_overflow    (overflow),
        .i_operand     (operand),
        .o_bcd_a       (bcdA),
        .o_bcd_b       (bcdB),
        .o_bcd_res     (bcdRes),
        .o_sign_q      (signQ),
        .o_overflow_q  (overflowQ),
        .o_operand_q   (operandQ),
        .o_busy        (busy),
        .o_update_done (updateDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [9:0] toBcd(input int n);
        logic [9:0] r;
        r[9:8] = 2'(n / 100);
        r[7:4] = 4'((n / 10) % 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    // Frame-level model: a snapshot is taken when idle, and 31 edges later everything lands.
    int         mTimer = 0;
    logic [7:0] mA, mB, mRes, mOp;
    logic       mSign, mOvf;
    logic [9:0] mBcdA = 10'h000;
    logic [9:0] mBcdB = 10'h000;
    logic [9:0] mBcdRes = 10'h000;
    logic       mSignQ = 1'b0;
    logic       mOvfQ = 1'b0;
    logic [7:0] mOpQ = 8'h00;
    logic       mDone = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mTimer  = 0;
            mBcdA   = 10'h000;
            mBcdB   = 10'h000;
            mBcdRes = 10'h000;
            mSignQ  = 1'b0;
            mOvfQ   = 1'b0;
            mOpQ    = 8'h00;
            mDone   = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mTimer == 0) begin
                if (frameStart) begin
                    mA = a; mB = b; mRes = result;
                    mSign = sign; mOvf = overflow; mOp = operand;
                    mTimer = 31;
                end
            end else begin
                mTimer = mTimer - 1;
                if (mTimer == 0) begin
                    mBcdA   = toBcd(int'(mA));
                    mBcdB   = toBcd(int'(mB));
                    mBcdRes = toBcd(int'(mRes));
                    mSignQ  = mSign;
                    mOvfQ   = mOvf;
                    mOpQ    = mOp;
                    mDone   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cmpBcdA", 32'(bcdA), 32'(mBcdA));
        checkOutput("cmpBcdB", 32'(bcdB), 32'(mBcdB));
        checkOutput("cmpBcdRes", 32'(bcdRes), 32'(mBcdRes));
        checkOutput("cmpSignQ", 32'(signQ), 32'(mSignQ));
        checkOutput("cmpOverflowQ", 32'(overflowQ), 32'(mOvfQ));
        checkOutput("cmpOperandQ", 32'(operandQ), 32'(mOpQ));
        checkOutput("cmpBusy", 32'(busy), 32'(mTimer != 0));
        checkOutput("cmpUpdateDone", 32'(updateDone), 32'(mDone));
        if (updateDone) donePulses++;
    end

    task automatic waitEdges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (busy) busyCount++;
        end
    endtask

    // Drive a snapshot's inputs and present frame_start for exactly one edge (edge 0).
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic [7:0] vr, input logic vs,
                                 input logic vo, input logic [7:0] vop);
        a = va; b = vb; result = vr; sign = vs; overflow = vo; operand = vop;
        frameStart = 1'b1;
        waitEdges(1);
        frameStart = 1'b0;
    endtask

    initial begin
        int doneBefore;
        logic [7:0] nb;

        #1;
        checkOutput("resetBusy", 32'(busy), 32'h0);
        checkOutput("resetBcdA", 32'(bcdA), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        waitEdges(2);

        // Basic conversion with handshake length.
        busyCount = 0;
        doneBefore = donePulses;
        applyStimulus(8'd255, 8'd0, 8'd128, 1'b1, 1'b0, 8'd43);
        waitEdges(30);
        checkOutput("basicHoldBcdA", 32'(bcdA), 32'h0);
        waitEdges(1);
        checkOutput("basicBcdA", 32'(bcdA), 32'h255);
        checkOutput("basicBcdB", 32'(bcdB), 32'h000);
        checkOutput("basicBcdRes", 32'(bcdRes), 32'h128);
        checkOutput("basicSignQ", 32'(signQ), 32'h1);
        checkOutput("basicOperandQ", 32'(operandQ), 32'd43);
        checkOutput("basicDone", 32'(updateDone), 32'h1);
        checkOutput("basicBusyLow", 32'(busy), 32'h0);
        waitEdges(3);
        checkOutput("basicBusyLen", 32'(busyCount), 32'd31);
        checkOutput("basicDoneCount", 32'(donePulses - doneBefore), 32'd1);

        // Snapshot isolation: late change to a waits for the next frame.
        applyStimulus(8'd99, 8'd1, 8'd2, 1'b0, 1'b1, 8'd7);
        waitEdges(5);
        a = 8'd7;
        waitEdges(26);
        checkOutput("isoFirstBcdA", 32'(bcdA), 32'h099);
        checkOutput("isoOverflowQ", 32'(overflowQ), 32'h1);
        waitEdges(2);
        applyStimulus(8'd7, 8'd1, 8'd2, 1'b0, 1'b0, 8'd7);
        waitEdges(31);
        checkOutput("isoSecondBcdA", 32'(bcdA), 32'h007);
        waitEdges(2);

        // A trigger during conversion is ignored.
        doneBefore = donePulses;
        applyStimulus(8'd12, 8'd34, 8'd56, 1'b0, 1'b0, 8'd1);
        waitEdges(11);
        a = 8'd200;
        frameStart = 1'b1;
        waitEdges(1);
        frameStart = 1'b0;
        waitEdges(19);
        checkOutput("ignoreDoneAt31", 32'(updateDone), 32'h1);
        checkOutput("ignoreBcdA", 32'(bcdA), 32'h012);
        waitEdges(40);
        checkOutput("ignoreDoneCount", 32'(donePulses - doneBefore), 32'd1);
        checkOutput("ignoreBusyLow", 32'(busy), 32'h0);

        // Asynchronous reset mid-conversion.
        applyStimulus(8'd200, 8'd150, 8'd77, 1'b1, 1'b1, 8'd9);
        waitEdges(14);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstBcdA", 32'(bcdA), 32'h0);
        checkOutput("rstBcdB", 32'(bcdB), 32'h0);
        checkOutput("rstBcdRes", 32'(bcdRes), 32'h0);
        checkOutput("rstOperandQ", 32'(operandQ), 32'h0);
        checkOutput("rstBusy", 32'(busy), 32'h0);
        doneBefore = donePulses;
        waitEdges(3);
        rst = 1'b0;
        waitEdges(40);
        checkOutput("rstNoDone", 32'(donePulses - doneBefore), 32'd0);
        applyStimulus(8'd42, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
        waitEdges(31);
        checkOutput("rstRecoverBcdA", 32'(bcdA), 32'h042);
        waitEdges(2);

        // frame_start held high retriggers on each idle cycle after commit.
        doneBefore = donePulses;
        a = 8'd5; b = 8'd6; result = 8'd7;
        frameStart = 1'b1;
        waitEdges(65);
        frameStart = 1'b0;
        waitEdges(35);
        checkOutput("heldDoneCount", 32'(donePulses - doneBefore), 32'd3);
        checkOutput("heldBcdRes", 32'(bcdRes), 32'h007);

        // Exhaustive sweep of all 8-bit values.
        for (int n = 0; n < 256; n++) begin
            nb = 8'(n);
            applyStimulus(nb, nb, nb, nb[0], nb[1], ~nb);
            waitEdges(31);
        end
        checkOutput("sweepLastBcdA", 32'(bcdA), 32'h255);
        checkOutput("sweepLastOperandQ", 32'(operandQ), 32'h00);

        waitEdges(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
